// File: rtl/delay_pkg.sv
// Shared definitions for the variable delay line.
//   clog2        : ceiling log2, used to size the delay/level fields
//   DELAY_BYPASS : delay value that selects the zero-latency bypass path
package delay_pkg;

  localparam int DELAY_BYPASS = 0;

  // Smallest r with 2**r >= value. Used on MAX_DELAY+1, so the result is
  // wide enough to hold every value 0..MAX_DELAY.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One storage stage of the delay line: a W-bit register with async reset,
// clock enable and a synchronous clear that overrides the enable.
//   clk   : clock
//   rst   : async active-high reset
//   ce_i  : load d_i when 1
//   clr_i : synchronous clear, priority over ce_i
//   d_i   : next stage contents
//   q_o   : stage contents
module delay_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        data_q <= '0;
    else if (clr_i) data_q <= '0;
    else if (ce_i)  data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/variable_delay_line.sv
// Delay line with a run-time selectable delay of 0..MAX_DELAY cycles,
// clock-enable stall, per-sample valid, synchronous flush and occupancy.
//   clk, rst  : clock, async active-high reset
//   ce        : pipeline advances only when 1 (input dropped when 0)
//   flush     : synchronous clear of every stage and level, beats ce
//   delay     : selected delay; values above MAX_DELAY saturate
//   ivalid    : input sample valid, idata: input sample
//   ovalid    : output valid, odata: output sample (0 when not valid)
//   level     : count of valid samples held in the stages
//   delay_err : registered, delay sampled at last edge exceeded MAX_DELAY
module variable_delay_line
  import delay_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int MAX_DELAY = 16,
  localparam int DW        = clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          flush,
  input  logic [DW-1:0] delay,
  input  logic          ivalid,
  input  logic [N-1:0]  idata,
  output logic          ovalid,
  output logic [N-1:0]  odata,
  output logic [DW-1:0] level,
  output logic          delay_err
);

  // Each stage is {valid, data}; data is forced to 0 for invalid samples so
  // a tap of an empty stage already reads as all-zero.
  logic [MAX_DELAY-1:0][N:0] stage_d;
  logic [MAX_DELAY-1:0][N:0] stage_q;

  assign stage_d[0] = {ivalid, ivalid ? idata : {N{1'b0}}};

  for (genvar k = 1; k < MAX_DELAY; k++) begin : g_shift
    assign stage_d[k] = stage_q[k-1];
  end

  for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
    delay_stage #(.W(N + 1)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .ce_i  (ce),
      .clr_i (flush),
      .d_i   (stage_d[k]),
      .q_o   (stage_q[k])
    );
  end

  // Effective delay saturates at MAX_DELAY.
  logic          over_range;
  logic [DW-1:0] de;

  assign over_range = (delay > DW'(MAX_DELAY));
  assign de         = over_range ? DW'(MAX_DELAY) : delay;

  // Tap select: de=k picks stage k-1. A compare loop keeps index widths
  // clean for any MAX_DELAY.
  logic [N:0] tap;

  always_comb begin
    tap = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (de == DW'(k + 1)) tap = stage_q[k];
    end
  end

  logic byp_v;
  assign byp_v = ivalid & ce;

  always_comb begin
    if (de == DW'(DELAY_BYPASS)) begin
      ovalid = byp_v;
      odata  = byp_v ? idata : '0;
    end else begin
      ovalid = tap[N];
      odata  = tap[N] ? tap[N-1:0] : '0;
    end
  end

  // Occupancy: +1 for an accepted valid, -1 for a valid leaving the last
  // stage. A full line always has a valid last stage, so no wrap.
  logic [DW-1:0] level_d, level_q;

  always_comb begin
    level_d = level_q;
    if (flush)   level_d = '0;
    else if (ce) level_d = level_q + DW'(ivalid) - DW'(stage_q[MAX_DELAY-1][N]);
  end

  logic delay_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= '0;
      delay_err_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      delay_err_q <= over_range;
    end
  end

  assign level     = level_q;
  assign delay_err = delay_err_q;

endmodule

// File: tb/tb_variable_delay_line.sv
module tb_variable_delay_line;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       flush;
  logic [2:0] delay;
  logic       ivalid;
  logic [2:0] idata;
  logic       ovalid;
  logic [2:0] odata;
  logic [2:0] level;
  logic       delay_err;

  int n_cmp = 0;
  int n_err = 0;

  variable_delay_line #(.N(3), .MAX_DELAY(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .flush     (flush),
    .delay     (delay),
    .ivalid    (ivalid),
    .idata     (idata),
    .ovalid    (ovalid),
    .odata     (odata),
    .level     (level),
    .delay_err (delay_err)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; flush = 1'b0; delay = 3'd4; ivalid = 1'b0; idata = 3'd0;
    tick();
    tick();
    n_cmp++;
    if (ovalid !== 1'b0 || odata !== 3'd0 || level !== 3'd0 || delay_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: ovalid=%b odata=%0d level=%0d err=%b, want 0 0 0 0",
               ovalid, odata, level, delay_err);
    end
    #2 rst = 1'b0;
  endtask

  // Test 1: delay 4, counting stream 0..7.
  task automatic test_stream();
    logic       ev;
    logic [2:0] ed, el;
    delay = 3'd4; ce = 1'b1; ivalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idata = 3'(i);
      tick();
      ev = (i >= 3);
      ed = ev ? 3'(i - 3) : 3'd0;
      el = (i >= 3) ? 3'd4 : 3'(i + 1);
      n_cmp++;
      if (ovalid !== ev || odata !== ed || level !== el) begin
        n_err++;
        $display("FAIL stream[%0d]: ovalid=%b odata=%0d level=%0d, want %b %0d %0d",
                 i, ovalid, odata, level, ev, ed, el);
      end
    end
    // stages now hold 7,6,5,4
  endtask

  // Test 3: stall 3 cycles, then resume without loss or duplication.
  task automatic test_stall();
    logic [2:0] exp_out [4];
    exp_out = '{3'd5, 3'd6, 3'd7, 3'd0};
    ce = 1'b0; ivalid = 1'b1; idata = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ovalid !== 1'b1 || odata !== 3'd4 || level !== 3'd4) begin
        n_err++;
        $display("FAIL stall[%0d]: ovalid=%b odata=%0d level=%0d, want 1 4 4",
                 i, ovalid, odata, level);
      end
    end
    ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idata = 3'(i);
      tick();
      n_cmp++;
      if (ovalid !== 1'b1 || odata !== exp_out[i] || level !== 3'd4) begin
        n_err++;
        $display("FAIL resume[%0d]: ovalid=%b odata=%0d level=%0d, want 1 %0d 4",
                 i, ovalid, odata, level, exp_out[i]);
      end
    end
    // stages now hold 3,2,1,0
  endtask

  // Test 4: run-time delay changes.
  task automatic test_delay_change();
    delay = 3'd2; #1;
    n_cmp++;
    if (odata !== 3'd2) begin
      n_err++; $display("FAIL dchg_2_imm: odata=%0d want 2", odata);
    end
    idata = 3'd4; tick();              // stages 4,3,2,1
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 3'd3) begin
      n_err++; $display("FAIL dchg_2_run: ovalid=%b odata=%0d want 1 3", ovalid, odata);
    end
    delay = 3'd4; idata = 3'd5; tick(); // stages 5,4,3,2
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 3'd2) begin
      n_err++; $display("FAIL dchg_to4: ovalid=%b odata=%0d want 1 2", ovalid, odata);
    end
    delay = 3'd2; #1;
    n_cmp++;
    if (odata !== 3'd4) begin
      n_err++; $display("FAIL dchg_back2: odata=%0d want 4", odata);
    end
    delay = 3'd1; #1;
    n_cmp++;
    if (odata !== 3'd5) begin
      n_err++; $display("FAIL dchg_1: odata=%0d want 5", odata);
    end
  endtask

  // Test 2: zero-latency bypass.
  task automatic test_bypass();
    delay = 3'd0; ce = 1'b1; ivalid = 1'b1; idata = 3'd5; #1;
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 3'd5) begin
      n_err++; $display("FAIL bypass_on: ovalid=%b odata=%0d want 1 5", ovalid, odata);
    end
    ce = 1'b0; #1;
    n_cmp++;
    if (ovalid !== 1'b0 || odata !== 3'd0) begin
      n_err++; $display("FAIL bypass_ce0: ovalid=%b odata=%0d want 0 0", ovalid, odata);
    end
    ce = 1'b1; ivalid = 1'b0; #1;
    n_cmp++;
    if (ovalid !== 1'b0 || odata !== 3'd0) begin
      n_err++; $display("FAIL bypass_iv0: ovalid=%b odata=%0d want 0 0", ovalid, odata);
    end
  endtask

  // Test 5: flush with a simultaneous valid input.
  task automatic test_flush();
    delay = 3'd4; ce = 1'b1; flush = 1'b1; ivalid = 1'b1; idata = 3'd7;
    tick();
    flush = 1'b0; ivalid = 1'b0; idata = 3'd0;
    n_cmp++;
    if (level !== 3'd0) begin
      n_err++; $display("FAIL flush_level: level=%0d want 0", level);
    end
    for (int d = 1; d <= 4; d++) begin
      delay = 3'(d); #1;
      n_cmp++;
      if (ovalid !== 1'b0 || odata !== 3'd0) begin
        n_err++; $display("FAIL flush_tap[%0d]: ovalid=%b odata=%0d want 0 0", d, ovalid, odata);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (ovalid !== 1'b0 || level !== 3'd0) begin
        n_err++; $display("FAIL flush_drain[%0d]: ovalid=%b level=%0d want 0 0", i, ovalid, level);
      end
    end
    // flush also wins when ce=0
    ivalid = 1'b1; idata = 3'd1; tick();
    ce = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; ce = 1'b1; ivalid = 1'b0;
    n_cmp++;
    if (level !== 3'd0) begin
      n_err++; $display("FAIL flush_ce0: level=%0d want 0", level);
    end
  endtask

  // Test 6: out-of-range delay saturates; async reset mid-stream.
  task automatic test_delay_err_reset();
    logic       ev;
    logic [2:0] ed, el;
    delay = 3'd6; ce = 1'b1; ivalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idata = 3'(i + 1);
      tick();
      ev = (i >= 3);
      ed = ev ? 3'(i - 2) : 3'd0;
      el = (i >= 3) ? 3'd4 : 3'(i + 1);
      n_cmp++;
      if (delay_err !== 1'b1 || ovalid !== ev || odata !== ed || level !== el) begin
        n_err++;
        $display("FAIL sat[%0d]: err=%b ovalid=%b odata=%0d level=%0d, want 1 %b %0d %0d",
                 i, delay_err, ovalid, odata, level, ev, ed, el);
      end
    end
    rst = 1'b1; #1;
    n_cmp++;
    if (ovalid !== 1'b0 || odata !== 3'd0 || level !== 3'd0 || delay_err !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: ovalid=%b odata=%0d level=%0d err=%b, want 0 0 0 0",
               ovalid, odata, level, delay_err);
    end
    #1 rst = 1'b0;
    delay = 3'd2; ivalid = 1'b1; idata = 3'd6;
    tick();
    ivalid = 1'b0; idata = 3'd0;
    n_cmp++;
    if (ovalid !== 1'b0 || delay_err !== 1'b0 || level !== 3'd1) begin
      n_err++;
      $display("FAIL post_rst_1: ovalid=%b err=%b level=%0d, want 0 0 1", ovalid, delay_err, level);
    end
    tick();
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 3'd6) begin
      n_err++; $display("FAIL post_rst_2: ovalid=%b odata=%0d want 1 6", ovalid, odata);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_delay_change();
    test_bypass();
    test_flush();
    test_delay_err_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/variable_delay_line.md
Name: variable_delay_line

Overview:
Parametrised successor to the fixed delay_line. It adds a runtime-selectable delay of 0..MAX_DELAY cycles, a clock-enable stall, and per-sample valid tracking. It also provides a synchronous flush and an occupancy counter. It sits in streaming datapaths where alignment latency is configured at run time rather than at synthesis.

Parameters:
N, 8, data width in bits (≥1)
MAX_DELAY, 16, number of storage stages; maximum selectable delay (≥1)
DW, $clog2(MAX_DELAY+1), localparam: width of delay and level

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ce  in  1  clock enable; pipeline advances only when 1
flush  in  1  synchronous clear of all stored samples
delay  in  DW  selected delay in cycles, 0..MAX_DELAY
ivalid  in  1  input sample valid
idata  in  N  input sample
ovalid  out  1  output sample valid
odata  out  N  output sample, zero when ovalid=0
level  out  DW  number of valid samples currently stored
delay_err  out  1  registered flag: last sampled delay exceeded MAX_DELAY

Behaviour:
- Storage: stage[0..MAX_DELAY-1], each {v, d[N-1:0]}.
- Reset (async, rst=1):
  - all stage v and d = 0
  - level = 0, delay_err = 0
  - hence ovalid = 0 and odata = 0 (for delay=0, these follow the bypass rule below)
- Advance (ce=1, flush=0, rising edge):
  - stage[0] <= {ivalid, ivalid ? idata : 0}
  - stage[k] <= stage[k-1] for k = 1..MAX_DELAY-1
  - the sample leaving stage[MAX_DELAY-1] is discarded
- Stall (ce=0, flush=0): all stages and level hold; ivalid is ignored (the sample is dropped, not queued).
- Flush (flush=1 at an edge):
  - all stages and level cleared to 0, regardless of ce
  - the input presented that cycle is discarded
  - flush has priority over ce
- Effective delay: de = min(delay, MAX_DELAY).
- Output tap (combinational from state and delay):
  - de = 0: ovalid = ivalid & ce, odata = ovalid ? idata : 0 (bypass, zero latency)
  - de ≥ 1: {ovalid, odata} = stage[de-1]
  - a sample accepted at edge t appears at the output after edge t+de-1, i.e. de cycles of advance
  - with ce=0 the output holds the tapped stage value
- Delay change: takes effect immediately on the tap.
  - Shortening drops samples older than the new tap from view; they remain stored until shifted out.
  - Lengthening exposes older stages; stages that never received a valid sample read ovalid=0.
  - No glitch suppression is required.
- level:
  - On advance: level <= level + ivalid − stage[MAX_DELAY-1].v.
  - On stall: level holds.
  - On flush: level <= 0.
  - Range is 0..MAX_DELAY; it never wraps.
  - level is independent of delay.
- delay_err: at every edge (regardless of ce), delay_err <= (delay > MAX_DELAY). Out-of-range values saturate to MAX_DELAY as defined above.
- Simultaneous flush + ce + ivalid: flush wins; level = 0 next cycle.
- Reset mid-stream: immediate clear. The first valid output after reset release appears de advancing cycles after the first accepted sample.

Decomposition:
- Shared package delay_pkg:
  - function clog2, used for DW
  - constant DELAY_BYPASS = 0
- One natural sub-module: delay_stage, an N+1-bit register with async reset, ce, and synchronous clear. It is instantiated MAX_DELAY times via generate.
- The tap mux and the level counter stay in the top module.

Test Plan:
1. N=3, MAX_DELAY=4, delay=4, ce=1, ivalid=1, idata counting 0,1,2… → ovalid rises 4 cycles after first valid edge; odata sequence 0,1,2… lagging idata by 4; level ramps 1,2,3,4 then holds at 4.
2. delay=0, ivalid=1, idata=5 → same-cycle ovalid=1, odata=5; with ce=0 → ovalid=0, odata=0.
3. Steady stream at delay=4, ce held 0 for 3 cycles → odata and level frozen; on resume, sequence continues with no missing or duplicated values.
4. Stream at delay=2, switch to delay=4 mid-stream → next cycle odata = sample two older than before; switch back to 2 → newer sample visible immediately.
5. level=4, assert flush together with ivalid=1, idata=7 → next cycle level=0, ovalid=0 for every delay≥1; 7 never appears at output.
6. delay=6 with MAX_DELAY=4 → delay_err=1 after next edge, behaviour identical to delay=4; assert rst asynchronously mid-stream → ovalid, odata, level, delay_err all 0 without waiting for a clock edge.
